// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states, requester id.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package alu_arb_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Two requesters, so one bit identifies the owner.
  typedef logic req_id_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: is_legal_op = 1'b1;
      default:                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/yAlu.sv
// 32-bit combinational ALU: AND, OR, ADD, SUB, signed SLT.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the inputs.
// Ports: z   - result (0 for illegal opcodes)
//        ex  - high when op is not a legal opcode
//        a,b - operands; op - 3-bit opcode
module yAlu
  import alu_arb_pkg::*;
(
  output logic [31:0] z,
  output logic        ex,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op
);

  always_comb begin
    z = 32'h0;
    case (op)
      OP_AND: z = a & b;
      OP_OR:  z = a | b;
      OP_ADD: z = a + b;
      OP_SUB: z = a - b;
      // Signed compare handles operands of differing sign correctly.
      OP_SLT: z = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      default: z = 32'h0;
    endcase
  end

  assign ex = ~is_legal_op(op);

endmodule

// File: rtl/alu_share_arb.sv
// Shares one yAlu between two requesters with round-robin arbitration and a 3-state FSM.
// Latency: grant in cycle N gives rsp_valid in N+2; at most one operation per 2 cycles.
// Backpressure: the response is held until the owner's rsp_ready; no new grant meanwhile.
// Ports: clk, reset (async, active high)
//        req_valid/req_ready/req_a/req_b/req_op - per-requester operation handshake
//        rsp_valid/rsp_ready                    - per-requester response handshake
//        rsp_z/rsp_zero/rsp_err                 - shared response payload
//        req_lock                               - per-requester grant hold (ALU_ARB_LOCK_EN only)
// Optional feature macro: ALU_ARB_LOCK_EN enables the grant lock.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2  // only 2 is supported
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][31:0] req_a,
  input  logic [NREQ-1:0][31:0] req_b,
  input  logic [NREQ-1:0][2:0]  req_op,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]       req_lock,
`endif
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [31:0]           rsp_z,
  output logic                  rsp_zero,
  output logic                  rsp_err
);

  state_t        state_q, state_d;
  req_id_t       owner_q;
  req_id_t       rr_q;      // requester preferred on a tie
  logic [31:0]   a_q, b_q;
  logic [2:0]    op_q;

  logic          rsp_accept;
  logic          arb_en;
  logic [NREQ-1:0] elig;
  logic          gnt_vld;
  req_id_t       gnt_id;

  logic [31:0]   alu_z;
  logic          alu_ex;
  logic [31:0]   res;

`ifdef ALU_ARB_LOCK_EN
  logic          lock_vld_q;
  req_id_t       lock_id_q;
`endif

  // Arbitration runs in IDLE and in the RESP cycle that the owner accepts,
  // so back-to-back operations need only EXEC+RESP per op.
  assign rsp_accept = (state_q == ST_RESP) && rsp_ready[owner_q];
  assign arb_en     = ~reset && ((state_q == ST_IDLE) || rsp_accept);

`ifdef ALU_ARB_LOCK_EN
  // While a lock is held only the holder is visible to the arbiter.
  always_comb begin
    elig = req_valid;
    if (lock_vld_q)
      elig = req_valid & (lock_id_q ? 2'b10 : 2'b01);
  end
`else
  assign elig = req_valid;
`endif

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = rr_q;
    if (arb_en) begin
      case (elig)
        2'b01: begin gnt_vld = 1'b1; gnt_id = 1'b0; end
        2'b10: begin gnt_vld = 1'b1; gnt_id = 1'b1; end
        2'b11: begin gnt_vld = 1'b1; gnt_id = rr_q; end
        default: gnt_vld = 1'b0;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_vld)
      req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == ST_RESP)
      rsp_valid[owner_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_vld) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_accept) state_d = gnt_vld ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Operand capture and round-robin pointer move together on a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      op_q    <= OP_AND;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
    end else if (gnt_vld) begin
      a_q     <= req_a[gnt_id];
      b_q     <= req_b[gnt_id];
      op_q    <= req_op[gnt_id];
      owner_q <= gnt_id;
      rr_q    <= ~gnt_id;
    end
  end

`ifdef ALU_ARB_LOCK_EN
  // Any grant to the holder without req_lock releases it; non-holders
  // cannot be granted while the lock is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_vld_q <= 1'b0;
      lock_id_q  <= 1'b0;
    end else if (gnt_vld) begin
      if (req_lock[gnt_id]) begin
        lock_vld_q <= 1'b1;
        lock_id_q  <= gnt_id;
      end else begin
        lock_vld_q <= 1'b0;
      end
    end
  end
`endif

  yAlu u_alu (
    .z  (alu_z),
    .ex (alu_ex),
    .a  (a_q),
    .b  (b_q),
    .op (op_q)
  );

  // Illegal opcodes discard the ALU output and report a zero result.
  assign res = alu_ex ? 32'h0 : alu_z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_z    <= 32'h0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      rsp_z    <= res;
      rsp_zero <= (res == 32'h0);
      rsp_err  <= alu_ex;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: reset, latency, round-robin, stall, illegal op,
// wrap, mid-operation reset and (with ALU_ARB_LOCK_EN) the grant lock.
// Inputs are driven at the falling edge; outputs are sampled 1 time unit later.
module tb_alu_share_arb;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][2:0]  req_op;
`ifdef ALU_ARB_LOCK_EN
  logic [1:0]       req_lock;
`endif
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_z;
  logic             rsp_zero;
  logic             rsp_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.NREQ(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
`ifdef ALU_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    req_op[i] = op;
    req_a[i]  = a;
    req_b[i]  = b;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'h0);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, " rsp_z"},     rsp_z,          32'h0);
    chk({tag, " rsp_zero"},  32'(rsp_zero),  32'h0);
    chk({tag, " rsp_err"},   32'(rsp_err),   32'h0);
  endtask

  initial begin
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
`ifdef ALU_ARB_LOCK_EN
    req_lock  = 2'b00;
`endif

    // Reset: outputs quiet even with both requests pending.
    #2;
    chk_idle_outs("reset");
    @(negedge clk);
    reset = 1'b0;
    req_valid = 2'b00;

    // Simultaneous requests held: grants 0,1,0.
    @(negedge clk);
    set_op(0, 3'b110, 32'd3, 32'd3);
    set_op(1, 3'b001, 32'hF0, 32'h0F);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1 chk("rr gnt0", 32'(req_ready), 32'h1);
    @(negedge clk); #1;
    chk("rr exec ready", 32'(req_ready), 32'h0);
    chk("rr exec valid", 32'(rsp_valid), 32'h0);
    @(negedge clk); #1;
    chk("rr rsp0 valid", 32'(rsp_valid), 32'h1);
    chk("rr rsp0 z", rsp_z, 32'h0);
    chk("rr rsp0 zero", 32'(rsp_zero), 32'h1);
    chk("rr gnt1", 32'(req_ready), 32'h2);
    @(negedge clk); #1;
    chk("rr exec2 valid", 32'(rsp_valid), 32'h0);
    @(negedge clk); #1;
    chk("rr rsp1 valid", 32'(rsp_valid), 32'h2);
    chk("rr rsp1 z", rsp_z, 32'hFF);
    chk("rr rsp1 zero", 32'(rsp_zero), 32'h0);
    chk("rr gnt0 again", 32'(req_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("rr rsp0b valid", 32'(rsp_valid), 32'h1);
    chk("rr rsp0b z", rsp_z, 32'h0);
    chk("rr drain ready", 32'(req_ready), 32'h0);

    // Single request, ADD 5+7, latency N -> N+2.
    @(negedge clk);
    rsp_ready = 2'b00;
    set_op(0, 3'b010, 32'd5, 32'd7);
    req_valid = 2'b01;
    #1 chk("add gnt", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("add n+1 valid", 32'(rsp_valid), 32'h0);
    @(negedge clk); #1;
    chk("add n+2 valid", 32'(rsp_valid), 32'h1);
    chk("add z", rsp_z, 32'd12);
    chk("add zero", 32'(rsp_zero), 32'h0);
    chk("add err", 32'(rsp_err), 32'h0);
    rsp_ready = 2'b01;

    // Stall on SLT -1<1 from requester 1 while requester 0 waits.
    @(negedge clk);
    rsp_ready = 2'b00;
    set_op(1, 3'b111, 32'hFFFF_FFFF, 32'd1);
    set_op(0, 3'b000, 32'hF0F0, 32'hFF00);
    req_valid = 2'b11;
    #1 chk("slt gnt1", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 2'b01;
    #1 chk("slt exec ready", 32'(req_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rsp_ready = 2'b01;  // non-owner ready must be ignored
      #1;
      chk("stall valid", 32'(rsp_valid), 32'h2);
      chk("stall z", rsp_z, 32'h1);
      chk("stall no gnt", 32'(req_ready), 32'h0);
    end
    @(negedge clk);
    rsp_ready = 2'b10;
    #1;
    chk("release valid", 32'(rsp_valid), 32'h2);
    chk("release gnt0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #1 chk("and exec valid", 32'(rsp_valid), 32'h0);
    @(negedge clk); #1;
    chk("and valid", 32'(rsp_valid), 32'h1);
    chk("and z", rsp_z, 32'hF000);
    rsp_ready = 2'b01;

    // Illegal opcode 100.
    @(negedge clk);
    rsp_ready = 2'b00;
    set_op(1, 3'b100, 32'd1, 32'd2);
    req_valid = 2'b10;
    #1 chk("ill gnt", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("ill n+1 valid", 32'(rsp_valid), 32'h0);
    @(negedge clk); #1;
    chk("ill valid", 32'(rsp_valid), 32'h2);
    chk("ill err", 32'(rsp_err), 32'h1);
    chk("ill z", rsp_z, 32'h0);
    chk("ill zero", 32'(rsp_zero), 32'h1);
    rsp_ready = 2'b10;

    // ADD wrap FFFFFFFF + 1.
    @(negedge clk);
    rsp_ready = 2'b00;
    set_op(0, 3'b010, 32'hFFFF_FFFF, 32'd1);
    req_valid = 2'b01;
    #1 chk("wrap gnt", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); #1;
    chk("wrap valid", 32'(rsp_valid), 32'h1);
    chk("wrap z", rsp_z, 32'h0);
    chk("wrap zero", 32'(rsp_zero), 32'h1);
    chk("wrap err", 32'(rsp_err), 32'h0);
    rsp_ready = 2'b01;

    // Reset during EXEC: abandoned, pointer back to requester 0.
    @(negedge clk);
    rsp_ready = 2'b00;
    set_op(1, 3'b001, 32'h1234, 32'h0);
    req_valid = 2'b11;
    #1 chk("rst gnt1", 32'(req_ready), 32'h2);
    @(negedge clk);
    reset = 1'b1;
    #1 chk_idle_outs("rst exec");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst after valid", 32'(rsp_valid), 32'h0);
    chk("rst after gnt0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("rst exec valid", 32'(rsp_valid), 32'h0);
    @(negedge clk); #1;
    chk("rst new rsp valid", 32'(rsp_valid), 32'h1);
    chk("rst new rsp z", rsp_z, 32'h0);
    rsp_ready = 2'b11;

`ifdef ALU_ARB_LOCK_EN
    // Requester 1 locks for 3 operations while requester 0 waits.
    @(negedge clk);
    set_op(1, 3'b001, 32'h1, 32'h2);
    req_valid = 2'b10;
    req_lock  = 2'b10;
    #1 chk("lock gnt1 a", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 2'b11;
    #1 chk("lock exec ready", 32'(req_ready), 32'h0);
    @(negedge clk); #1;
    chk("lock rsp valid", 32'(rsp_valid), 32'h2);
    chk("lock gnt1 b", 32'(req_ready), 32'h2);
    @(negedge clk);
    @(negedge clk);
    req_lock = 2'b00;
    #1 chk("lock gnt1 c", 32'(req_ready), 32'h2);
    @(negedge clk);
    @(negedge clk); #1;
    chk("lock released gnt0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter: NREQ, default 2, number of requesters; only 2 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req_valid  input  [1:0]  per-requester operation request.
REQ-005 Port: req_ready  output  [1:0]  per-requester grant; a transfer occurs when valid and ready are both high.
REQ-006 Port: req_a, req_b  input  2x[31:0] each  per-requester operands.
REQ-007 Port: req_op  input  2x[2:0]  per-requester opcode.
REQ-008 Port: rsp_valid  output  [1:0]  result available for the owning requester.
REQ-009 Port: rsp_ready  input  [1:0]  per-requester result accept.
REQ-010 Port: rsp_z  output  [31:0]  result value, shared by both requesters and qualified by rsp_valid.
REQ-011 Port: rsp_zero  output  1  result-equals-zero flag.
REQ-012 Port: rsp_err  output  1  illegal-opcode flag.
REQ-013 Port: req_lock  input  [1:0]  per-requester grant hold; present only with ALU_ARB_LOCK_EN.

Function
REQ-014 Legal opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed); 011, 100 and 101 are illegal.
REQ-015 FSM states: IDLE, EXEC, RESP.
REQ-016 IDLE: arbitrate; on a grant, latch the requester's operands, opcode and id, then go to EXEC.
REQ-017 EXEC lasts exactly 1 cycle: the ALU evaluates the latched operands, and the result, zero flag and error flag are registered; then go to RESP.
REQ-018 RESP: hold rsp_valid[owner]=1 with stable rsp_z, rsp_zero and rsp_err until rsp_ready[owner]=1.
REQ-019 RESP with rsp_ready[owner]=1: arbitrate in the same cycle; go to EXEC on a grant, otherwise go to IDLE.
REQ-020 Latency: a grant in cycle N gives rsp_valid in cycle N+2; back-to-back throughput is 1 operation per 2 cycles.
REQ-021 req_ready is high only in IDLE or in accepting RESP, at most one bit at a time, and only for a requester whose req_valid is high.
REQ-022 Arbitration is round-robin: a single request is granted immediately; with simultaneous requests, the requester not granted last wins.
REQ-023 The round-robin pointer updates only on a grant; its reset value favours requester 0.
REQ-024 Illegal opcode: rsp_err=1, rsp_z=0, rsp_zero=1; the ALU result is discarded and the handshake timing is unchanged.
REQ-025 rsp_zero=1 exactly when the registered rsp_z equals 0.
REQ-026 ADD and SUB wrap modulo 2^32; no overflow is reported.
REQ-027 SLT returns 32'h1 when a<b signed, otherwise 0, and is correct when the operand signs differ.
REQ-028 rsp_valid for the non-owner requester stays 0.
REQ-029 rsp_ready on a requester with rsp_valid=0 is ignored.
REQ-030 req_valid deasserted without a grant is legal; nothing is latched.

Reset
REQ-031 When reset is asserted: state=IDLE, req_ready=0, rsp_valid=0, rsp_z=0, rsp_zero=0, rsp_err=0, round-robin pointer=requester 0, lock holder cleared.
REQ-032 Reset asserted mid-operation abandons the in-flight operation with no response; the first grant is possible in the first cycle after reset deasserts.

Configuration
REQ-033 The feature macro is ALU_ARB_LOCK_EN.
REQ-034 With ALU_ARB_LOCK_EN defined: a requester granted with req_lock=1 becomes lock holder, and only it may be granted until it completes a transfer with req_lock=0.
REQ-035 With ALU_ARB_LOCK_EN defined, reset clears the lock holder.
REQ-036 Without ALU_ARB_LOCK_EN: the req_lock port is absent, and arbitration is pure round-robin.

Structure
REQ-037 Shared package alu_arb_pkg: opcode constants, FSM state enum, requester-id type, and an is_legal_op function.
REQ-038 One sub-module, the team's existing 32-bit combinational ALU yAlu (ports z, ex, a, b, op), instantiated once and fed only from the latched operand registers.
REQ-039 No other sub-modules; the arbiter and FSM are inline.

Verification
REQ-040 Single request: req0 ADD a=5, b=7 -> req_ready[0] in cycle N, rsp_valid[0] in N+2, rsp_z=12, rsp_zero=0.
REQ-041 Simultaneous requests, both held: req0 SUB 3-3 and req1 OR F0|0F -> grants alternate 0,1,0; responses 0 (rsp_zero=1) and 32'hFF.
REQ-042 Response stall: rsp_ready[1]=0 for 4 cycles on SLT a=-1, b=1 -> rsp_z=1 held stable, no new grants, release on ready.
REQ-043 Illegal op: op=100 -> rsp_err=1, rsp_z=0, rsp_zero=1, 2-cycle latency preserved; wrap: ADD FFFFFFFF+1 -> 0, rsp_zero=1.
REQ-044 Reset asserted in EXEC -> no rsp_valid afterwards, all outputs 0, next simultaneous request grants requester 0.
REQ-045 With ALU_ARB_LOCK_EN defined, requester 1 locked for 3 operations while req0 stays pending -> req0 is not granted until req1 completes its transfer with req_lock=0.
